// File: rtl/i2c_reg_master.sv
// Single-master I2C register-protocol initiator: one register write or read per request.
// SCL/SDA are driven open-drain through output enables; sda_i is the sampled bus level.
`timescale 1ns/1ps

module i2c_reg_master #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rw,
    input  logic [6:0] sl_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ACK_A, S_REG, S_ACK_R, S_WDATA, S_ACK_W,
        S_RSTART, S_ADDR_RD, S_ACK_A2, S_RDATA, S_MNACK, S_STOP
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_div;
    logic [1:0]  r_q;
    logic [2:0]  r_bit;
    logic        r_busy, r_done, r_ack_err;
    logic [7:0]  r_rdata, r_shift;
    logic        r_rw;
    logic [6:0]  r_addr;
    logic [7:0]  r_reg, r_wdata;
    logic        r_scl_oe, r_sda_d, r_sda_oe;
    logic        r_sda_s1, r_sda_s2;

    logic        w_start, w_tick, w_q_end, w_sample;
    logic        w_is_ack, w_is_bit;
    logic        w_scl_want, w_sda_want;
    logic [7:0]  w_tx_byte;

    assign w_start  = req && !r_busy;
    assign w_tick   = r_busy && (r_div == DIV_MAX);
    assign w_q_end  = w_tick && (r_q == 2'd3);
    assign w_sample = w_tick && (r_q == 2'd2);
    assign w_is_ack = (r_state == S_ACK_A) || (r_state == S_ACK_R) ||
                      (r_state == S_ACK_W) || (r_state == S_ACK_A2);
    assign w_is_bit = (r_state == S_ADDR) || (r_state == S_REG) || (r_state == S_WDATA) ||
                      (r_state == S_ADDR_RD) || (r_state == S_RDATA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scl_want  = 1'b0;
        w_sda_want  = 1'b0;
        w_tx_byte   = 8'h00;
        case (r_state)
            S_ADDR:    w_tx_byte = {r_addr, 1'b0};
            S_REG:     w_tx_byte = r_reg;
            S_WDATA:   w_tx_byte = r_wdata;
            S_ADDR_RD: w_tx_byte = {r_addr, 1'b1};
            default:   w_tx_byte = 8'h00;
        endcase
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_START;
            end
            S_START: begin
                w_scl_want = (r_q == 2'd3);
                w_sda_want = (r_q != 2'd0);
                if (w_q_end) w_state_nxt = S_ADDR;
            end
            S_ADDR, S_REG, S_WDATA, S_ADDR_RD: begin
                w_scl_want = (r_q == 2'd0);
                w_sda_want = ~w_tx_byte[3'd7 - r_bit];
                if (w_q_end && r_bit == 3'd7) begin
                    case (r_state)
                        S_ADDR:  w_state_nxt = S_ACK_A;
                        S_REG:   w_state_nxt = S_ACK_R;
                        S_WDATA: w_state_nxt = S_ACK_W;
                        default: w_state_nxt = S_ACK_A2;
                    endcase
                end
            end
            S_ACK_A: begin
                w_scl_want = (r_q == 2'd0);
                if (w_q_end) w_state_nxt = r_ack_err ? S_STOP : S_REG;
            end
            S_ACK_R: begin
                w_scl_want = (r_q == 2'd0);
                if (w_q_end) w_state_nxt = r_ack_err ? S_STOP : (r_rw ? S_RSTART : S_WDATA);
            end
            S_ACK_W: begin
                w_scl_want = (r_q == 2'd0);
                if (w_q_end) w_state_nxt = S_STOP;
            end
            S_ACK_A2: begin
                w_scl_want = (r_q == 2'd0);
                if (w_q_end) w_state_nxt = r_ack_err ? S_STOP : S_RDATA;
            end
            S_RDATA: begin
                w_scl_want = (r_q == 2'd0);
                if (w_q_end && r_bit == 3'd7) w_state_nxt = S_MNACK;
            end
            S_MNACK: begin
                w_scl_want = (r_q == 2'd0);
                if (w_q_end) w_state_nxt = S_STOP;
            end
            S_RSTART: begin
                w_scl_want = (r_q == 2'd0) || (r_q == 2'd3);
                w_sda_want = r_q[1];
                if (w_q_end) w_state_nxt = S_ADDR_RD;
            end
            S_STOP: begin
                w_scl_want = (r_q == 2'd0);
                w_sda_want = (r_q != 2'd3);
                if (w_q_end) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // SDA enable trails SCL by one extra clock so data only moves once SCL is already low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div     <= 16'd0;
            r_q       <= 2'd0;
            r_bit     <= 3'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_rdata   <= 8'h00;
            r_shift   <= 8'h00;
            r_rw      <= 1'b0;
            r_addr    <= 7'h00;
            r_reg     <= 8'h00;
            r_wdata   <= 8'h00;
            r_scl_oe  <= 1'b0;
            r_sda_d   <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_sda_s1  <= 1'b1;
            r_sda_s2  <= 1'b1;
        end else begin
            r_done   <= 1'b0;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
            r_scl_oe <= w_scl_want;
            r_sda_d  <= w_sda_want;
            r_sda_oe <= r_sda_d;
            if (w_start) begin
                r_busy    <= 1'b1;
                r_rw      <= rw;
                r_addr    <= sl_addr;
                r_reg     <= reg_addr;
                r_wdata   <= wdata;
                r_ack_err <= 1'b0;
                r_div     <= 16'd0;
                r_q       <= 2'd0;
                r_bit     <= 3'd0;
            end else if (r_busy) begin
                r_div <= w_tick ? 16'd0 : r_div + 16'd1;
                if (w_tick) r_q <= r_q + 2'd1;
                if (w_q_end && w_is_bit) r_bit <= r_bit + 3'd1;
                if (w_sample && w_is_ack && r_sda_s2) r_ack_err <= 1'b1;
                if (w_sample && r_state == S_RDATA) r_shift <= {r_shift[6:0], r_sda_s2};
                if (w_q_end && r_state == S_STOP) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    if (r_rw && !r_ack_err) r_rdata <= r_shift;
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign ack_err = r_ack_err;
    assign rdata   = r_rdata;
    assign scl_oe  = r_scl_oe;
    assign sda_oe  = r_sda_oe;

endmodule

// File: tb/tb_i2c_reg_master.sv
// Directed bench for i2c_reg_master: two register-slave models on an open-drain bus,
// transaction timing, NACK handling, mid-transfer reset and START/STOP event counting.
`timescale 1ns/1ps

module tb_i2c_reg_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] sl_addr = 7'h00;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       busy, done, ack_err, scl_oe, sda_oe;
    logic [7:0] rdata;
    logic [1:0] drv = 2'b00;
    logic       bus_scl, bus_sda;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;
    int n_stop = 0;
    int n_drv0 = 0;

    assign bus_scl = ~scl_oe;
    assign bus_sda = ~(sda_oe | drv[0] | drv[1]);

    always #5 clk = ~clk;

    i2c_reg_master #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .req(req), .rw(rw), .sl_addr(sl_addr),
        .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done),
        .ack_err(ack_err), .rdata(rdata), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .sda_i(bus_sda)
    );

    // Slave models: 0 = RX byte, 1 = driving ACK, 2 = TX byte, 3 = master ACK slot, 4 = idle
    initial begin
        logic [7:0] mem [2][8];
        logic [6:0] saddr [2];
        int         sst [2];
        int         kind [2];
        int         cnt [2];
        logic [7:0] sh [2];
        logic [7:0] ptr [2];
        logic [7:0] txb [2];
        logic       rdf [2];
        logic       p_scl, p_sda, scl_now, sda_now;
        logic [7:0] t;
        saddr[0] = 7'h10;
        saddr[1] = 7'h20;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) mem[s][i] = 8'h00;
            sst[s] = 4; kind[s] = 0; cnt[s] = 0; sh[s] = 8'h00;
            ptr[s] = 8'h00; txb[s] = 8'h00; rdf[s] = 1'b0;
        end
        mem[0][4] = 8'h12; mem[0][5] = 8'h34; mem[0][6] = 8'h56; mem[0][7] = 8'h78;
        mem[1][4] = 8'h90; mem[1][5] = 8'h12; mem[1][6] = 8'h34; mem[1][7] = 8'h56;
        p_scl = 1'b1;
        p_sda = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int s = 0; s < 2; s++) begin
                    sst[s] = 4;
                    drv[s] = 1'b0;
                end
                p_scl = 1'b1;
                p_sda = 1'b1;
            end else begin
                scl_now = bus_scl;
                sda_now = bus_sda;
                if (scl_now && p_scl && (sda_now != p_sda)) begin
                    if (!sda_now) n_start++;
                    else          n_stop++;
                    for (int s = 0; s < 2; s++) begin
                        sst[s] = sda_now ? 4 : 0;
                        kind[s] = 0;
                        cnt[s] = 0;
                        drv[s] = 1'b0;
                    end
                end else if (scl_now && !p_scl) begin
                    for (int s = 0; s < 2; s++) begin
                        if (sst[s] == 0) begin
                            sh[s] = {sh[s][6:0], sda_now};
                            cnt[s]++;
                        end
                    end
                end else if (!scl_now && p_scl) begin
                    for (int s = 0; s < 2; s++) begin
                        case (sst[s])
                            0: if (cnt[s] == 8) begin
                                if (kind[s] == 0) begin
                                    if (sh[s][7:1] == saddr[s]) begin
                                        rdf[s] = sh[s][0];
                                        drv[s] = 1'b1;
                                        sst[s] = 1;
                                    end else begin
                                        sst[s] = 4;
                                    end
                                end else if (kind[s] == 1) begin
                                    ptr[s] = sh[s];
                                    drv[s] = 1'b1;
                                    sst[s] = 1;
                                end else begin
                                    mem[s][ptr[s][2:0]] = sh[s];
                                    ptr[s] = ptr[s] + 8'd1;
                                    drv[s] = 1'b1;
                                    sst[s] = 1;
                                end
                            end
                            1: begin
                                drv[s] = 1'b0;
                                if (kind[s] == 0 && rdf[s]) begin
                                    txb[s] = mem[s][ptr[s][2:0]];
                                    t = txb[s];
                                    drv[s] = ~t[7];
                                    cnt[s] = 1;
                                    sst[s] = 2;
                                end else begin
                                    sst[s] = 0;
                                    cnt[s] = 0;
                                    kind[s] = (kind[s] == 0) ? 1 : 2;
                                end
                            end
                            2: begin
                                if (cnt[s] == 8) begin
                                    drv[s] = 1'b0;
                                    sst[s] = 3;
                                end else begin
                                    t = txb[s];
                                    drv[s] = ~t[7 - cnt[s]];
                                    cnt[s]++;
                                end
                            end
                            3: begin
                                drv[s] = 1'b0;
                                sst[s] = 4;
                            end
                            default: drv[s] = 1'b0;
                        endcase
                    end
                end
                p_scl = scl_now;
                p_sda = sda_now;
                if (drv[0]) n_drv0++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one request and waits (bounded) for done; optionally pulses req again at cycle poke_at.
    task automatic run_txn(input logic i_rw, input logic [6:0] a, input logic [7:0] r,
                           input logic [7:0] d, input int poke_at,
                           output int cyc, output int gaps, output int ns, output int np);
        int s0, p0;
        s0 = n_start;
        p0 = n_stop;
        @(negedge clk);
        rw = i_rw; sl_addr = a; reg_addr = r; wdata = d; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        cyc = 0;
        gaps = 0;
        do begin
            if (!busy) gaps++;
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == poke_at) begin
                req = 1'b1; rw = ~i_rw; sl_addr = 7'h10; reg_addr = 8'h06; wdata = 8'h3C;
            end else begin
                req = 1'b0;
            end
        end while (!done && cyc < 2000);
        req = 1'b0;
        check("busy_at_done", 32'(busy), 32'd0);
        ns = n_start - s0;
        np = n_stop - p0;
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int cyc, gaps, ns, np, d0;

        repeat (5) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'h00);
        check("rst_scl_oe", 32'(scl_oe), 32'd0);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);

        run_txn(1'b1, 7'h10, 8'h04, 8'h00, -1, cyc, gaps, ns, np);
        check("t1_cycles", 32'(cyc), 32'd624);
        check("t1_busy_gaps", 32'(gaps), 32'd0);
        check("t1_ack_err", 32'(ack_err), 32'd0);
        check("t1_rdata", 32'(rdata), 32'h12);
        check("t1_starts", 32'(ns), 32'd2);
        check("t1_stops", 32'(np), 32'd1);

        d0 = n_drv0;
        run_txn(1'b1, 7'h20, 8'h07, 8'h00, -1, cyc, gaps, ns, np);
        check("t2_cycles", 32'(cyc), 32'd624);
        check("t2_ack_err", 32'(ack_err), 32'd0);
        check("t2_rdata", 32'(rdata), 32'h56);
        check("t2_slave10_quiet", 32'(n_drv0 - d0), 32'd0);

        run_txn(1'b0, 7'h10, 8'h00, 8'hA5, -1, cyc, gaps, ns, np);
        check("t3_wr_cycles", 32'(cyc), 32'd464);
        check("t3_wr_ack_err", 32'(ack_err), 32'd0);
        check("t3_wr_rdata_held", 32'(rdata), 32'h56);
        check("t3_wr_starts", 32'(ns), 32'd1);
        check("t3_wr_stops", 32'(np), 32'd1);
        run_txn(1'b1, 7'h10, 8'h00, 8'h00, -1, cyc, gaps, ns, np);
        check("t3_rd_rdata", 32'(rdata), 32'hA5);
        check("t3_rd_ack_err", 32'(ack_err), 32'd0);

        run_txn(1'b1, 7'h30, 8'h04, 8'h00, -1, cyc, gaps, ns, np);
        check("t4_cycles", 32'(cyc), 32'd176);
        check("t4_ack_err", 32'(ack_err), 32'd1);
        check("t4_rdata_held", 32'(rdata), 32'hA5);
        check("t4_starts", 32'(ns), 32'd1);
        check("t4_stops", 32'(np), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("t4_ack_err_held", 32'(ack_err), 32'd1);

        @(negedge clk);
        rw = 1'b1; sl_addr = 7'h10; reg_addr = 8'h04; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (476) @(posedge clk);
        #1;
        check("t5_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("t5_rst_scl_oe", 32'(scl_oe), 32'd0);
        check("t5_rst_sda_oe", 32'(sda_oe), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_rdata", 32'(rdata), 32'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        run_txn(1'b1, 7'h10, 8'h05, 8'h00, -1, cyc, gaps, ns, np);
        check("t5_cycles", 32'(cyc), 32'd624);
        check("t5_ack_err", 32'(ack_err), 32'd0);
        check("t5_rdata", 32'(rdata), 32'h34);

        run_txn(1'b0, 7'h20, 8'h05, 8'h77, 100, cyc, gaps, ns, np);
        check("t6_cycles", 32'(cyc), 32'd464);
        check("t6_ack_err", 32'(ack_err), 32'd0);
        check("t6_starts", 32'(ns), 32'd1);
        check("t6_stops", 32'(np), 32'd1);
        check("t6_rdata_held", 32'(rdata), 32'h34);
        repeat (10) @(posedge clk);
        #1;
        check("t6_no_queued_req", 32'(busy), 32'd0);
        run_txn(1'b1, 7'h20, 8'h05, 8'h00, -1, cyc, gaps, ns, np);
        check("t6_rd_rdata", 32'(rdata), 32'h77);
        run_txn(1'b1, 7'h10, 8'h06, 8'h00, -1, cyc, gaps, ns, np);
        check("t6_rd_untouched", 32'(rdata), 32'h56);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
